// File: rtl/lsu_pkg.sv
// Shared state encoding, funct3 codes and address window for the load/store unit.
// size_bytes returns 0 for funct3 values that are not RV32 load/store sizes.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_ADDR,
        LD_WAIT,
        ST_RD,
        ST_RDWAIT,
        ST_WR,
        RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] LSU_BASE_ADDR = 32'h0000_2000;
    localparam logic [31:0] LSU_END_ADDR  = 32'h0000_3FFF;

    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: size_bytes = 3'd1;
            F3_H, F3_HU: size_bytes = 3'd2;
            F3_W:        size_bytes = 3'd4;
            default:     size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_dmem_ctrl_if.sv
// Core-side request/response and d_mem-side bus of the load/store unit.
// Handshake: a request transfers on the rising edge where i_req && o_ready; o_rsp_valid is a one-cycle pulse.
interface lsu_dmem_ctrl_if;

    logic        i_req;
    logic        o_ready;
    logic        i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [31:0] o_mem_addr;
    logic        o_mem_wren;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rdata,
        output o_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_mem_addr, o_mem_wren, o_mem_wdata
    );

    modport master (
        output i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rdata,
        input  o_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_mem_addr, o_mem_wren, o_mem_wdata
    );

endinterface

// File: rtl/d_mem.sv
// Word-organised data RAM: synchronous write, registered read (data valid the cycle after the address).
module d_mem #(
    parameter int WORDS = 2048
) (
    input  logic        i_clk,
    input  logic [31:0] i_addr,
    input  logic        i_wren,
    input  logic [31:0] i_data_in,
    output logic [31:0] o_data_out
);

    localparam int AW = $clog2(WORDS);

    logic [31:0]   mem_q [WORDS];
    logic [31:0]   rdata_q;
    logic [AW-1:0] idx;
    logic          unused_addr_bits;

    assign idx              = i_addr[AW+1:2];
    assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0]};
    assign o_data_out       = rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_wren) mem_q[idx] <= i_data_in;
        rdata_q <= mem_q[idx];
    end

endmodule

// File: rtl/lsu_lane_fmt.sv
// Byte/half lane handling: extracts and extends load data, and merges sub-word store data into a word.
module lsu_lane_fmt
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_st_word
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = i_word[{i_addr_lo, 3'b000} +: 8];
        lane_h = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

        case (i_funct3)
            F3_B:    o_ld_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   o_ld_data = {24'd0, lane_b};
            F3_H:    o_ld_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   o_ld_data = {16'd0, lane_h};
            default: o_ld_data = i_word;
        endcase

        // Untouched lanes of the read word pass through unchanged.
        o_st_word = i_word;
        case (i_funct3)
            F3_B: o_st_word[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
            F3_H: begin
                if (i_addr_lo[1]) o_st_word[31:16] = i_wdata[15:0];
                else              o_st_word[15:0]  = i_wdata[15:0];
            end
            default: o_st_word = i_wdata;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit: one request at a time, sub-word stores as read-modify-write, registered responses.
// Faulty requests go straight to RESP without touching d_mem.
module lsu_dmem_ctrl
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = LSU_BASE_ADDR,
    parameter logic [31:0] END_ADDR  = LSU_END_ADDR
) (
    input  logic           i_clk,
    input  logic           i_rst,
    lsu_dmem_ctrl_if.slave bus,
    output lsu_state_t     o_dbg_state
);

    lsu_state_t  state_q, state_d;
    logic [1:0]  lo_q, lo_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] data_q, data_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_wren_q, mem_wren_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        ready_q, ready_d;

    logic [2:0]  req_size;
    logic [32:0] last_byte;
    logic        req_err;
    logic [31:0] ld_fmt;
    logic [31:0] st_merge;

    lsu_lane_fmt u_lane_fmt (
        .i_word    (bus.i_mem_rdata),
        .i_wdata   (wdata_q),
        .i_addr_lo (lo_q),
        .i_funct3  (f3_q),
        .o_ld_data (ld_fmt),
        .o_st_word (st_merge)
    );

    // 33-bit end address so a request near 2^32 cannot wrap back into range.
    always_comb begin
        req_size  = size_bytes(bus.i_funct3);
        last_byte = {1'b0, bus.i_addr} + {30'd0, req_size} - 33'd1;
        req_err   = (req_size == 3'd0) || (bus.i_we && bus.i_funct3[2])
                 || ((req_size == 3'd2) && bus.i_addr[0])
                 || ((req_size == 3'd4) && (bus.i_addr[1:0] != 2'b00))
                 || (bus.i_addr < BASE_ADDR) || (last_byte > {1'b0, END_ADDR});
    end

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        we_d        = we_q;
        f3_d        = f3_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        data_d      = data_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_req && ready_q) begin
                    lo_d    = bus.i_addr[1:0];
                    we_d    = bus.i_we;
                    f3_d    = bus.i_funct3;
                    wdata_d = bus.i_wdata;
                    err_d   = req_err;
                    if (req_err) begin
                        state_d = RESP;
                    end else begin
                        mem_addr_d = {bus.i_addr[31:2], 2'b00};
                        if (!bus.i_we) begin
                            state_d = LD_ADDR;
                        end else if (bus.i_funct3 == F3_W) begin
                            state_d     = ST_WR;
                            mem_wdata_d = bus.i_wdata;
                        end else begin
                            state_d = ST_RD;
                        end
                    end
                end
            end
            LD_ADDR:   state_d = LD_WAIT;
            LD_WAIT: begin
                data_d  = ld_fmt;
                state_d = RESP;
            end
            ST_RD:     state_d = ST_RDWAIT;
            ST_RDWAIT: begin
                mem_wdata_d = st_merge;
                state_d     = ST_WR;
            end
            ST_WR:     state_d = RESP;
            RESP: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                rsp_rdata_d = (we_q || err_q) ? 32'd0 : data_q;
            end
            default:   state_d = IDLE;
        endcase

        // Ready stays low during the response pulse so transactions never overlap.
        mem_wren_d = (state_d == ST_WR);
        ready_d    = (state_d == IDLE) && !rsp_valid_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            lo_q        <= 2'd0;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            wdata_q     <= 32'd0;
            err_q       <= 1'b0;
            data_q      <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_wren_q  <= 1'b0;
            mem_wdata_q <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            data_q      <= data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wren_q  <= mem_wren_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.o_ready     = ready_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_rdata = rsp_rdata_q;
    assign bus.o_rsp_err   = rsp_err_q;
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_wren  = mem_wren_q;
    assign bus.o_mem_wdata = mem_wdata_q;
    assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Bench for lsu_dmem_ctrl with a real d_mem: directed and random requests, checked by a
// scoreboard against a byte-level memory model.
module tb_lsu_dmem_ctrl;
    import lsu_pkg::*;

    localparam int EXP_W = 45;  // {rdata[31:0], err, latency[7:0], wren_cycles[3:0]}

    logic       clk = 1'b0;
    logic       rst;
    lsu_state_t dbg_state;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         wren_cnt = 0;

    logic [EXP_W-1:0] exp_q[$];
    int               acc_q[$];
    logic [31:0]      ref_mem [int unsigned];

    lsu_dmem_ctrl_if bus ();

    lsu_dmem_ctrl #(
        .BASE_ADDR (32'h0000_2000),
        .END_ADDR  (32'h0000_3FFF)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    d_mem #(.WORDS(2048)) u_mem (
        .i_clk      (clk),
        .i_addr     (bus.o_mem_addr),
        .i_wren     (bus.o_mem_wren),
        .i_data_in  (bus.o_mem_wdata),
        .o_data_out (bus.i_mem_rdata)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference model: RV32 access rules in plain arithmetic on a word-indexed memory.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, output logic err, output logic [31:0] rd,
                                  output int lat, output int nwr);
        int          size;
        int          sh;
        logic [63:0] word, val, mask;
        int unsigned key;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err  = 1'b0;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (we && f3[2])) err = 1'b1;
        else if ((addr % size) != 0) err = 1'b1;
        else if (addr < 32'h2000 || (longint'(addr) + size - 1) > 64'h3FFF) err = 1'b1;
        rd  = 32'd0;
        nwr = 0;
        if (err) begin
            lat = 2;
            return;
        end
        key  = addr >> 2;
        word = ref_mem.exists(key) ? {32'd0, ref_mem[key]} : 64'd0;
        sh   = 8 * int'(addr % 4);
        mask = (64'd1 << (8 * size)) - 64'd1;
        if (we) begin
            word = (word & ~(mask << sh)) | (({32'd0, wd} & mask) << sh);
            ref_mem[key] = word[31:0];
            nwr = 1;
            lat = (size == 4) ? 3 : 5;
        end else begin
            val = (word >> sh) & mask;
            if (!f3[2] && size < 4 && val[8*size-1]) val = val - (mask + 64'd1);
            rd  = val[31:0];
            lat = 4;
        end
    endfunction

    // ---------------- driver ----------------
    task automatic wait_ready();
        int waited;
        waited = 0;
        while (!bus.o_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.o_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: o_ready=%0b after %0d cycles, required 1", bus.o_ready, waited);
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        logic        e;
        logic [31:0] rd;
        int          lat, nwr;
        wait_ready();
        if (!bus.o_ready) return;
        bus.i_req    = 1'b1;
        bus.i_we     = we;
        bus.i_funct3 = f3;
        bus.i_addr   = addr;
        bus.i_wdata  = wd;
        model(we, f3, addr, wd, e, rd, lat, nwr);
        exp_q.push_back({rd, e, 8'(lat), 4'(nwr)});
        acc_q.push_back(cyc + 1);
        @(negedge clk);
        // Request fields are captured at accept; scramble them afterwards.
        bus.i_req    = 1'b0;
        bus.i_we     = 1'($urandom_range(0, 1));
        bus.i_funct3 = 3'($urandom_range(0, 7));
        bus.i_addr   = $urandom();
        bus.i_wdata  = $urandom();
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [EXP_W-1:0] mon_e;
    int               mon_acc;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_mem_wren) wren_cnt++;
            if (bus.o_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: rdata=0x%08h err=%0b, required no response", bus.o_rsp_rdata, bus.o_rsp_err);
                end else begin
                    mon_e   = exp_q.pop_front();
                    mon_acc = acc_q.pop_front();
                    check("rsp_rdata", bus.o_rsp_rdata, mon_e[44:13]);
                    check("rsp_err", {31'd0, bus.o_rsp_err}, {31'd0, mon_e[12]});
                    check("latency", cyc + 1 - mon_acc, {24'd0, mon_e[11:4]});
                    check("wren_cycles", wren_cnt, {28'd0, mon_e[3:0]});
                    check("ready_during_rsp", {31'd0, bus.o_ready}, 32'd0);
                end
                wren_cnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int          waited;
        logic [31:0] addr;
        rst          = 1'b1;
        bus.i_req    = 1'b0;
        bus.i_we     = 1'b0;
        bus.i_funct3 = 3'd0;
        bus.i_addr   = 32'd0;
        bus.i_wdata  = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_ready", {31'd0, bus.o_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, bus.o_rsp_err}, 32'd0);
        check("rst_rsp_rdata", bus.o_rsp_rdata, 32'd0);
        check("rst_mem_wren", {31'd0, bus.o_mem_wren}, 32'd0);
        check("rst_mem_addr", bus.o_mem_addr, 32'd0);
        check("rst_mem_wdata", bus.o_mem_wdata, 32'd0);

        // Word store / load
        issue(1'b1, F3_W, 32'h2004, 32'hDEAD_BEEF);
        issue(1'b0, F3_W, 32'h2004, 32'h0);

        // Byte RMW and byte loads
        issue(1'b1, F3_W, 32'h2008, 32'h1122_3344);
        issue(1'b1, F3_B, 32'h200A, 32'h0000_00AA);
        issue(1'b0, F3_W, 32'h2008, 32'h0);
        issue(1'b0, F3_B, 32'h200A, 32'h0);
        issue(1'b0, F3_BU, 32'h200A, 32'h0);

        // Half loads
        issue(1'b1, F3_W, 32'h2010, 32'h8001_7FFF);
        issue(1'b0, F3_H, 32'h2010, 32'h0);
        issue(1'b0, F3_H, 32'h2012, 32'h0);
        issue(1'b0, F3_HU, 32'h2012, 32'h0);

        // Faulty requests
        issue(1'b0, F3_W, 32'h2002, 32'h0);
        issue(1'b1, F3_W, 32'h1FFC, 32'h1234_5678);
        issue(1'b0, F3_W, 32'h4000, 32'h0);
        issue(1'b0, 3'b011, 32'h2004, 32'h0);
        issue(1'b1, F3_BU, 32'h2004, 32'h0000_0055);

        // Top-of-range boundary
        issue(1'b1, F3_W, 32'h3FFC, 32'h0102_0304);
        issue(1'b1, F3_H, 32'h3FFE, 32'h0000_BEEF);
        issue(1'b0, F3_W, 32'h3FFC, 32'h0);
        issue(1'b0, F3_W, 32'h3FFD, 32'h0);

        // Random traffic over an initialised window plus out-of-range and boundary addresses
        for (int i = 0; i < 16; i++) issue(1'b1, F3_W, 32'h2100 + 32'(4 * i), $urandom());
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0:       addr = 32'h1FF0 + 32'($urandom_range(0, 15));
                1:       addr = 32'h4000 + 32'($urandom_range(0, 15));
                2, 3:    addr = 32'h3FFC + 32'($urandom_range(0, 3));
                default: addr = 32'h2100 + 32'($urandom_range(0, 63));
            endcase
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom());
        end

        // Reset while an SB is waiting for its read data: no response, no write
        wait_ready();
        bus.i_req    = 1'b1;
        bus.i_we     = 1'b1;
        bus.i_funct3 = F3_B;
        bus.i_addr   = 32'h2004;
        bus.i_wdata  = 32'h0000_0055;
        waited       = 0;
        while (dbg_state != ST_RDWAIT && waited < 20) begin
            @(negedge clk);
            bus.i_req = 1'b0;
            waited++;
        end
        if (dbg_state != ST_RDWAIT) begin
            checks++;
            failures++;
            $display("FAIL abort_reach_rdwait: state=%0d after %0d cycles, required ST_RDWAIT", dbg_state, waited);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", {31'd0, bus.o_ready}, 32'd1);
        check("abort_rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
        check("abort_wren", wren_cnt, 32'd0);
        check("abort_pending", exp_q.size(), 32'd0);
        issue(1'b0, F3_W, 32'h2004, 32'h0);

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("drain_outstanding", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
